mmio_completer: RTL and testbench

MMIO_COMPLETER -- requirements
Module: mmio_completer

---
 rtl/mmio_completer.sv | 236 +++++++++++++++++++++++
 tb/tb_mmio_completer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_completer.sv
// BAR0 MMIO completer: decodes 3DW MWr32/MRd32 from the RX stream, serves a
// four-register map and answers reads with a two-beat CplD on the TX stream.
module mmio_completer #(
  parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
  input  logic        user_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] m_axis_rx_tdata,
  input  logic [7:0]  m_axis_rx_tkeep,
  input  logic        m_axis_rx_tlast,
  input  logic        m_axis_rx_tvalid,
  output logic        m_axis_rx_tready,
  input  logic        m_axis_rx_bar0,
  output logic [63:0] s_axis_tx_tdata,
  output logic [7:0]  s_axis_tx_tkeep,
  output logic        s_axis_tx_tlast,
  output logic        s_axis_tx_tvalid,
  input  logic        s_axis_tx_tready,
  input  logic [3:0]  dipsw,
  input  logic [4:0]  buttons,
  output logic [7:0]  led
);

  localparam int unsigned DW_W  = 32;
  localparam int unsigned LED_W = 8;

  localparam logic [6:0] FT_MWR32 = 7'b1000000;
  localparam logic [6:0] FT_MRD32 = 7'b0000000;
  localparam logic [6:0] FT_CPLD  = 7'b1001010;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR2, S_DROP, S_CPL0, S_CPL1
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        fmt_q, fmt_d;
  logic [2:0]        tc_q, tc_d;
  logic [1:0]        attr_q, attr_d;
  logic [9:0]        len_q, len_d;
  logic [15:0]       req_id_q, req_id_d;
  logic [7:0]        tag_q, tag_d;
  logic [3:0]        be_q, be_d;
  logic              bar0_q, bar0_d;
  logic [4:0]        addr_q, addr_d;
  logic [DW_W-1:0]   rdata_q, rdata_d;
  logic              pend_q, pend_d;
  logic              rdy_q, rdy_d;
  logic              tx_valid_q, tx_valid_d;
  logic [63:0]       tx_data_q, tx_data_d;
  logic [7:0]        tx_keep_q, tx_keep_d;
  logic              tx_last_q, tx_last_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DW_W-1:0]   scratch_q, scratch_d;
  logic [DW_W-1:0]   cycles_q;

  logic              rx_acc, tx_acc, req_ok, wr_en, rd_ok;
  logic [DW_W-1:0]   dw2, dw3, rd_mux;
  logic [DW_W-1:0]   cpl_dw0, cpl_dw1, cpl_dw2;
  logic              unused_bits;

  assign unused_bits = ^{m_axis_rx_tkeep, m_axis_rx_tdata};

  assign rx_acc = m_axis_rx_tvalid & rdy_q;
  assign tx_acc = tx_valid_q & s_axis_tx_tready;
  assign dw2    = m_axis_rx_tdata[31:0];
  assign dw3    = m_axis_rx_tdata[63:32];
  assign req_ok = bar0_q & (len_q == 10'd1);
  assign wr_en  = (state_q == S_HDR2) & rx_acc & req_ok & (fmt_q == FT_MWR32);
  assign rd_ok  = req_ok & (fmt_q == FT_MRD32);

  // Only address bits [3:2] select a register; everything above aliases.
  always_comb begin
    rd_mux = '0;
    case (dw2[3:2])
      2'd0:    rd_mux = DW_W'(led_q);
      2'd1:    rd_mux = DW_W'({buttons, dipsw});
      2'd2:    rd_mux = scratch_q;
      default: rd_mux = cycles_q;
    endcase
  end

  assign cpl_dw0 = {1'b0, FT_CPLD, 1'b0, tc_q, 4'b0, 2'b00, attr_q, 2'b00, 10'd1};
  assign cpl_dw1 = {COMPLETER_ID, 3'b000, 1'b0, 12'd4};
  assign cpl_dw2 = {req_id_q, tag_q, 1'b0, addr_q, 2'b00};

  // Register writes with first-BE byte masking; RO slots ignore writes.
  always_comb begin
    led_d     = led_q;
    scratch_d = scratch_q;
    if (wr_en) begin
      case (dw2[3:2])
        2'd0: if (be_q[0]) led_d = dw3[7:0];
        2'd2: begin
          for (int b = 0; b < 4; b++) begin
            if (be_q[b]) scratch_d[8*b +: 8] = dw3[8*b +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    fmt_d      = fmt_q;
    tc_d       = tc_q;
    attr_d     = attr_q;
    len_d      = len_q;
    req_id_d   = req_id_q;
    tag_d      = tag_q;
    be_d       = be_q;
    bar0_d     = bar0_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    pend_d     = pend_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_keep_d  = tx_keep_q;
    tx_last_d  = tx_last_q;

    case (state_q)
      S_IDLE: begin
        if (rx_acc) begin
          fmt_d    = m_axis_rx_tdata[30:24];
          tc_d     = m_axis_rx_tdata[22:20];
          attr_d   = m_axis_rx_tdata[13:12];
          len_d    = m_axis_rx_tdata[9:0];
          req_id_d = m_axis_rx_tdata[63:48];
          tag_d    = m_axis_rx_tdata[47:40];
          be_d     = m_axis_rx_tdata[35:32];
          bar0_d   = m_axis_rx_bar0;
          if (!m_axis_rx_tlast) state_d = S_HDR2;
        end
      end
      S_HDR2: begin
        if (rx_acc) begin
          if (rd_ok) begin
            addr_d  = dw2[6:2];
            rdata_d = rd_mux;
            if (m_axis_rx_tlast) begin
              state_d = S_CPL0;
            end else begin
              pend_d  = 1'b1;
              state_d = S_DROP;
            end
          end else begin
            state_d = m_axis_rx_tlast ? S_IDLE : S_DROP;
          end
        end
      end
      S_DROP: begin
        if (rx_acc && m_axis_rx_tlast) begin
          state_d = pend_q ? S_CPL0 : S_IDLE;
          pend_d  = 1'b0;
        end
      end
      S_CPL0:  if (tx_acc) state_d = S_CPL1;
      S_CPL1:  if (tx_acc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // TX beat is loaded on state entry and held until accepted.
    if (state_d == S_CPL0 && state_q != S_CPL0) begin
      tx_valid_d = 1'b1;
      tx_data_d  = {cpl_dw1, cpl_dw0};
      tx_keep_d  = 8'hFF;
      tx_last_d  = 1'b0;
    end else if (state_d == S_CPL1 && state_q == S_CPL0) begin
      tx_valid_d = 1'b1;
      tx_data_d  = {rdata_q, cpl_dw2};
      tx_keep_d  = 8'hFF;
      tx_last_d  = 1'b1;
    end else if (state_d != S_CPL0 && state_d != S_CPL1) begin
      tx_valid_d = 1'b0;
      tx_data_d  = '0;
      tx_keep_d  = '0;
      tx_last_d  = 1'b0;
    end

    rdy_d = (state_d == S_IDLE) || (state_d == S_HDR2) || (state_d == S_DROP);
  end

  always_ff @(posedge user_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      fmt_q      <= '0;
      tc_q       <= '0;
      attr_q     <= '0;
      len_q      <= '0;
      req_id_q   <= '0;
      tag_q      <= '0;
      be_q       <= '0;
      bar0_q     <= 1'b0;
      addr_q     <= '0;
      rdata_q    <= '0;
      pend_q     <= 1'b0;
      rdy_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_keep_q  <= '0;
      tx_last_q  <= 1'b0;
      led_q      <= '0;
      scratch_q  <= '0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      fmt_q      <= fmt_d;
      tc_q       <= tc_d;
      attr_q     <= attr_d;
      len_q      <= len_d;
      req_id_q   <= req_id_d;
      tag_q      <= tag_d;
      be_q       <= be_d;
      bar0_q     <= bar0_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      pend_q     <= pend_d;
      rdy_q      <= rdy_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_keep_q  <= tx_keep_d;
      tx_last_q  <= tx_last_d;
      led_q      <= led_d;
      scratch_q  <= scratch_d;
      cycles_q   <= cycles_q + DW_W'(1);
    end
  end

  assign m_axis_rx_tready = rdy_q;
  assign s_axis_tx_tvalid = tx_valid_q;
  assign s_axis_tx_tdata  = tx_data_q;
  assign s_axis_tx_tkeep  = tx_keep_q;
  assign s_axis_tx_tlast  = tx_last_q;
  assign led              = led_q;

endmodule

// File: tb/tb_mmio_completer.sv
// Scoreboard bench for mmio_completer: directed MMIO requests, expected CplD
// beats queued at issue time and checked by an independent TX monitor.
module tb_mmio_completer;

  logic        user_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [63:0] rx_tdata = '0;
  logic [7:0]  rx_tkeep = '0;
  logic        rx_tlast = 1'b0;
  logic        rx_tvalid = 1'b0;
  logic        rx_tready;
  logic        rx_bar0 = 1'b0;
  logic [63:0] tx_tdata;
  logic [7:0]  tx_tkeep;
  logic        tx_tlast;
  logic        tx_tvalid;
  logic        tx_tready = 1'b1;
  logic [3:0]  dipsw = 4'hC;
  logic [4:0]  buttons = 5'h11;
  logic [7:0]  led;

  mmio_completer #(.COMPLETER_ID(16'h0100)) dut (
    .user_clk(user_clk), .sys_rst_n(sys_rst_n),
    .m_axis_rx_tdata(rx_tdata), .m_axis_rx_tkeep(rx_tkeep),
    .m_axis_rx_tlast(rx_tlast), .m_axis_rx_tvalid(rx_tvalid),
    .m_axis_rx_tready(rx_tready), .m_axis_rx_bar0(rx_bar0),
    .s_axis_tx_tdata(tx_tdata), .s_axis_tx_tkeep(tx_tkeep),
    .s_axis_tx_tlast(tx_tlast), .s_axis_tx_tvalid(tx_tvalid),
    .s_axis_tx_tready(tx_tready),
    .dipsw(dipsw), .buttons(buttons), .led(led)
  );

  always #5 user_clk = ~user_clk;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } beat_t;

  beat_t       exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] tb_cyc;

  // Reference cycle count: clocks seen since reset release.
  always @(posedge user_clk or negedge sys_rst_n)
    if (!sys_rst_n) tb_cyc <= '0;
    else            tb_cyc <= tb_cyc + 32'd1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // TX monitor: every presented beat must be expected; accepted beats are compared.
  always @(negedge user_clk) begin
    if (sys_rst_n && tx_tvalid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_tx: got %h expected no beat", tx_tdata);
      end else if (tx_tready) begin
        beat_t e;
        e = exp_q.pop_front();
        check("cpl_beat", 80'({tx_tlast, tx_tkeep, tx_tdata}),
              80'({e.last, 8'hFF, e.data}));
      end
    end
  end

  function automatic logic [31:0] req_dw0(input logic [6:0] ft, input logic [2:0] tc,
                                          input logic [1:0] attr, input logic [9:0] len);
    return {1'b0, ft, 1'b0, tc, 4'b0, 2'b00, attr, 2'b00, len};
  endfunction

  // Drives one RX beat from posedge+1; returns at posedge+1 after acceptance.
  task automatic rx_beat(input logic [63:0] d, input logic last, input logic bar,
                         output logic [31:0] cyc);
    int n;
    n = 0;
    rx_tvalid = 1'b1; rx_tdata = d; rx_tkeep = 8'hFF; rx_tlast = last; rx_bar0 = bar;
    do begin
      @(negedge user_clk);
      n++;
    end while (!rx_tready && n < 200);
    cyc = tb_cyc;
    if (!rx_tready) check("rx_accept_timeout", 80'(rx_tready), 80'(1));
    @(posedge user_clk);
    #1;
    rx_tvalid = 1'b0; rx_tlast = 1'b0;
  endtask

  task automatic mwr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data,
                     input logic bar, input logic [9:0] len);
    logic [31:0] c;
    rx_beat({16'h0000, 8'h00, 4'h0, be, req_dw0(7'b1000000, 3'd0, 2'd0, len)}, 1'b0, bar, c);
    if (len == 10'd1) begin
      rx_beat({data, addr}, 1'b1, bar, c);
    end else begin
      rx_beat({data, addr}, 1'b0, bar, c);
      rx_beat({32'h0, data}, 1'b1, bar, c);
    end
  endtask

  task automatic mrd(input logic [31:0] addr, input logic [7:0] tag, input logic [15:0] rid,
                     input logic [2:0] tc, input logic [1:0] attr, input logic bar,
                     input logic [31:0] exp_data, input logic use_cyc);
    logic [31:0] c;
    beat_t b0, b1;
    rx_beat({rid, tag, 4'h0, 4'hF, req_dw0(7'b0000000, tc, attr, 10'd1)}, 1'b0, bar, c);
    rx_beat({32'h0, addr}, 1'b1, bar, c);
    if (bar) begin
      b0.last = 1'b0;
      b0.data = {16'h0100, 3'b000, 1'b0, 12'd4,
                 1'b0, 7'b1001010, 1'b0, tc, 4'b0, 2'b00, attr, 2'b00, 10'd1};
      b1.last = 1'b1;
      b1.data = {use_cyc ? c : exp_data, rid, tag, 1'b0, addr[6:2], 2'b00};
      exp_q.push_back(b0);
      exp_q.push_back(b1);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_tvalid) && n < 100) begin
      @(negedge user_clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 80'(exp_q.size()), 80'(0));
    repeat (3) @(negedge user_clk);
    @(posedge user_clk);
    #1;
  endtask

  task automatic wait_tvalid();
    int n;
    n = 0;
    while (!tx_tvalid && n < 50) begin
      @(negedge user_clk);
      n++;
    end
    if (!tx_tvalid) check("tvalid_timeout", 80'(tx_tvalid), 80'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held;

    #23;
    check("rst_led",       80'(led),       80'(0));
    check("rst_tvalid",    80'(tx_tvalid), 80'(0));
    check("rst_tdata",     80'(tx_tdata),  80'(0));
    check("rst_tkeep",     80'(tx_tkeep),  80'(0));
    check("rst_tlast",     80'(tx_tlast),  80'(0));
    check("rst_rx_tready", 80'(rx_tready), 80'(0));
    sys_rst_n = 1'b1;
    #1;
    check("rx_tready_before_clk", 80'(rx_tready), 80'(0));
    @(posedge user_clk);
    #1;
    check("rx_tready_after_clk", 80'(rx_tready), 80'(1));

    // Write LED, then read it back with non-zero TC/attr.
    mwr(32'h0, 4'hF, 32'h000000A5, 1'b1, 10'd1);
    check("led_after_write", 80'(led), 80'(8'hA5));
    wait_drain();
    mrd(32'h0, 8'h01, 16'hABCD, 3'd5, 2'd2, 1'b1, 32'h000000A5, 1'b0);
    wait_drain();

    // LED only takes byte 0; BE without bit 0 leaves it alone.
    mwr(32'h0, 4'b1110, 32'hFFFFFFFF, 1'b1, 10'd1);
    check("led_be_masked", 80'(led), 80'(8'hA5));

    // SCRATCH byte-masked write, readback and upper-address alias.
    mwr(32'h8, 4'hF, 32'h12345678, 1'b1, 10'd1);
    mwr(32'h8, 4'b0011, 32'hDEADBEEF, 1'b1, 10'd1);
    mrd(32'h8, 8'h17, 16'h0000, 3'd0, 2'd0, 1'b1, 32'h1234BEEF, 1'b0);
    wait_drain();
    mrd(32'h18, 8'h22, 16'h0102, 3'd0, 2'd0, 1'b1, 32'h1234BEEF, 1'b0);
    wait_drain();

    // Read-only switches/buttons; writes ignored.
    mrd(32'h4, 8'h30, 16'h0001, 3'd0, 2'd0, 1'b1, 32'h0000011C, 1'b0);
    wait_drain();
    mwr(32'h4, 4'hF, 32'hFFFFFFFF, 1'b1, 10'd1);
    mrd(32'h4, 8'h31, 16'h0001, 3'd0, 2'd0, 1'b1, 32'h0000011C, 1'b0);
    wait_drain();

    // Free-running counter value at the request's second beat.
    mrd(32'hC, 8'h40, 16'h0002, 3'd0, 2'd0, 1'b1, 32'h0, 1'b1);
    wait_drain();

    // Discards: multi-DW write and a non-BAR0 read.
    mwr(32'h0, 4'hF, 32'h00000055, 1'b1, 10'd2);
    check("discard_mwr_led", 80'(led), 80'(8'hA5));
    check("discard_idle_ready", 80'(rx_tready), 80'(1));
    mrd(32'h8, 8'h50, 16'h0003, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0);
    wait_drain();
    check("discard_mrd_ready", 80'(rx_tready), 80'(1));
    mrd(32'h0, 8'h51, 16'h0003, 3'd0, 2'd0, 1'b1, 32'h000000A5, 1'b0);
    wait_drain();

    // TX back-pressure held in CPL0 for five cycles.
    tx_tready = 1'b0;
    mrd(32'h8, 8'h33, 16'h0004, 3'd0, 2'd0, 1'b1, 32'h1234BEEF, 1'b0);
    wait_tvalid();
    held = tx_tdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge user_clk);
      check("bp_tdata_stable", 80'(tx_tdata), 80'(held));
      check("bp_rx_tready", 80'(rx_tready), 80'(0));
    end
    @(posedge user_clk);
    #1;
    tx_tready = 1'b1;
    wait_drain();

    // Reset pulse while CPL1 is stalled.
    tx_tready = 1'b0;
    mrd(32'h0, 8'h44, 16'h0005, 3'd0, 2'd0, 1'b1, 32'h000000A5, 1'b0);
    wait_tvalid();
    @(posedge user_clk);
    #1;
    tx_tready = 1'b1;
    @(posedge user_clk);
    #1;
    tx_tready = 1'b0;
    check("in_cpl1_tlast", 80'(tx_tlast), 80'(1));
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("rst_async_tvalid", 80'(tx_tvalid), 80'(0));
    check("rst_async_led", 80'(led), 80'(0));
    check("rst_async_rx_tready", 80'(rx_tready), 80'(0));
    exp_q.delete();
    #10;
    sys_rst_n = 1'b1;
    tx_tready = 1'b1;
    @(posedge user_clk);
    #1;
    mrd(32'h8, 8'h55, 16'h0006, 3'd0, 2'd0, 1'b1, 32'h00000000, 1'b0);
    wait_drain();
    mrd(32'h0, 8'h56, 16'h0006, 3'd0, 2'd0, 1'b1, 32'h00000000, 1'b0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
